cache_ddr_bridge: RTL and testbench
===================================

# cache_ddr_bridge

Downstream neighbour of the data cache: converts the cache's single-cycle 128-bit line read/write requests into the DDR2 memory controller's user (app) interface, and returns single-cycle completion pulses to the cache. Holds at most one pending read and one pending write, serves them one at a time, and gates all traffic on controller calibration.

## Interface
Parameters:
- LINE_W, 128, line width in bits (fixed at 128; one DDR burst per line)
- ADDR_W, 27, byte address width
- TIMEOUT_CYCLES, 4096, read-data watchdog limit (used only with DDR_BRIDGE_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- cache2DDR_rd_addr  in  27  line read byte address
- cache2DDR_rd_en  in  1  one-cycle read request pulse
- DDR2cache_rd_fin  out  1  one-cycle read completion pulse
- DDR2cache_rd_data  out  128  read line; valid with rd_fin, held until next rd_fin
- cache2DDR_wr_addr  in  27  line write byte address
- cache2DDR_wr_data  in  128  line write data
- cache2DDR_wr_en  in  1  one-cycle write request pulse
- DDR2cache_wr_fin  out  1  one-cycle write completion pulse
- app_addr  out  27  controller address = {addr[26:4], 4'b0000}
- app_cmd  out  3  3'b001 read, 3'b000 write
- app_en  out  1  command valid
- app_rdy  in  1  command accepted when app_en & app_rdy
- app_wdf_data  out  128  write data
- app_wdf_wren, app_wdf_end  out  1 each  write-data valid / last beat (always equal)
- app_wdf_mask  out  16  always 16'h0000
- app_wdf_rdy  in  1  write data accepted when wren & wdf_rdy
- app_rd_data  in  128  controller read data
- app_rd_data_valid  in  1  read data valid
- init_calib_complete  in  1  controller ready
- bridge_err  out  1  sticky timeout flag (tied 0 without DDR_BRIDGE_TIMEOUT_EN)

## Operation
- Request capture: rd_en/wr_en pulse latches addr (and data) into the read or write pending slot and sets its pending flag, in any state. Pulse for a type already pending or in service is ignored.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- IDLE: if !init_calib_complete, stay. Else write pending -> WR_ISSUE; else read pending -> RD_ISSUE. Write wins on simultaneous pending (including same-cycle pulses).
- WR_ISSUE: app_en and app_wdf_wren/end asserted from slot; each deasserts independently once accepted (cmd and data may be accepted in either order or same cycle). When both accepted: clear write pending, wr_fin=1 next cycle, -> IDLE.
- RD_ISSUE: app_en with cmd read until app_rdy; -> RD_WAIT.
- RD_WAIT: on app_rd_data_valid register data to DDR2cache_rd_data, rd_fin=1 next cycle, clear read pending, -> IDLE.
- app_rd_data_valid outside RD_WAIT is discarded.
- Reset values: all outputs 0 (rd_data 128'd0, app_cmd 3'b000, bridge_err 0), pending flags 0, state IDLE. Reset mid-transaction abandons it; no fin is ever issued for it.

## Timing
- Write: pulse cycle 0; app_en/wren high cycle 1; both accepted cycle 1 -> wr_fin high cycle 2 only. Minimum 2 cycles.
- Read: pulse cycle 0; app_en cycle 1; accepted cycle 1; valid cycle N -> rd_fin and data cycle N+1.
- fin pulses exactly one cycle; back-to-back service: next command issues the cycle after fin at earliest (IDLE one cycle).
- app_en never asserted while init_calib_complete low; requests latched during calibration issue after it rises.

## Configuration
- DDR_BRIDGE_TIMEOUT_EN defined: counter runs in RD_WAIT; reaching TIMEOUT_CYCLES with no valid -> rd_fin with data 128'd0, bridge_err set (sticky until reset), -> IDLE. Counter clears on entry to RD_WAIT.
- Undefined: no counter, RD_WAIT waits indefinitely, bridge_err constant 0.

## Structure
- Package ddr_bridge_pkg: state enum, CMD_READ=3'b001, CMD_WRITE=3'b000, LINE_W, line-align helper.
- One sub-module: ddr_req_slot (pending flag + addr/data register, capture/clear/ignore-when-busy), instantiated twice (read without data field).

## Test plan
- Write 0x0001230 data 128'hA5..A5, app_rdy=wdf_rdy=1 -> app_addr 0x0001230, wdf_mask 0, wr_fin cycle 2.
- Read 0x0001234, valid 10 cycles after accept with 128'h1122..FF -> app_addr 0x0001230, rd_fin + data next cycle.
- Same-cycle rd/wr pulses -> write issued first, wr_fin, then read issued; both fins once each.
- app_rdy accepted cycle 1, wdf_rdy low until cycle 5 -> wren held to cycle 5, wr_fin cycle 6.
- init_calib_complete low 20 cycles with read latched -> no app_en until rise, then normal read.
- rstn low during RD_WAIT, late valid after reset -> no rd_fin, data stays 0; with DDR_BRIDGE_TIMEOUT_EN, no valid for TIMEOUT_CYCLES -> rd_fin, data 0, bridge_err 1.

Source files
------------

// File: rtl/ddr_bridge_pkg.sv
// Shared types and constants for cache_ddr_bridge and its request slots.
package ddr_bridge_pkg;

    localparam int         LINE_W    = 128;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_WAIT
    } bridge_state_e;

    // Drops the byte offset inside a 16-byte line; callers cast to their address width.
    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return addr & ~64'hF;
    endfunction

endpackage

// File: rtl/ddr_req_slot.sv
// One pending-request slot: a flag plus a captured payload ({addr,data} or addr alone).
module ddr_req_slot #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cap,
    input  logic         clr,
    input  logic [W-1:0] cap_payload,
    output logic         pending,
    output logic [W-1:0] payload
);

    // A capture while the slot is occupied (pending or in service) is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= 1'b0;
            payload <= '0;
        end else if (clr) begin
            pending <= 1'b0;
        end else if (cap && !pending) begin
            pending <= 1'b1;
            payload <= cap_payload;
        end
    end

endmodule

// File: rtl/cache_ddr_bridge.sv
// Cache line requests to DDR2 app interface, one transaction at a time, writes first.
// Optional read-data watchdog enabled by defining DDR_BRIDGE_TIMEOUT_EN.
module cache_ddr_bridge #(
    parameter int LINE_W         = ddr_bridge_pkg::LINE_W,
    parameter int ADDR_W         = 27,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] cache2DDR_rd_addr,
    input  logic              cache2DDR_rd_en,
    output logic              DDR2cache_rd_fin,
    output logic [LINE_W-1:0] DDR2cache_rd_data,
    input  logic [ADDR_W-1:0] cache2DDR_wr_addr,
    input  logic [LINE_W-1:0] cache2DDR_wr_data,
    input  logic              cache2DDR_wr_en,
    output logic              DDR2cache_wr_fin,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [LINE_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [15:0]       app_wdf_mask,
    input  logic              app_wdf_rdy,
    input  logic [LINE_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              init_calib_complete,
    output logic              bridge_err
);
    import ddr_bridge_pkg::*;

    localparam int WR_W = ADDR_W + LINE_W;

    bridge_state_e     state;
    logic              wr_pend, rd_pend, wr_clr, rd_clr, rd_tmo;
    logic [WR_W-1:0]   wr_slot_q;
    logic [ADDR_W-1:0] rd_slot_q;
    logic              wr_req, rd_req, wr_cmd_done, wr_dat_done;
    logic [ADDR_W-1:0] wr_addr_eff, rd_addr_eff;
    logic [LINE_W-1:0] wr_data_eff;

    ddr_req_slot #(.W(WR_W)) u_wr_slot (
        .clk         (clk),
        .rstn        (rstn),
        .cap         (cache2DDR_wr_en),
        .clr         (wr_clr),
        .cap_payload ({cache2DDR_wr_addr, cache2DDR_wr_data}),
        .pending     (wr_pend),
        .payload     (wr_slot_q)
    );

    ddr_req_slot #(.W(ADDR_W)) u_rd_slot (
        .clk         (clk),
        .rstn        (rstn),
        .cap         (cache2DDR_rd_en),
        .clr         (rd_clr),
        .cap_payload (cache2DDR_rd_addr),
        .pending     (rd_pend),
        .payload     (rd_slot_q)
    );

    // IDLE also looks at same-cycle pulses so a fresh request issues the next cycle.
    assign wr_req = wr_pend | cache2DDR_wr_en;
    assign rd_req = rd_pend | cache2DDR_rd_en;
    assign {wr_addr_eff, wr_data_eff} = wr_pend ? wr_slot_q
                                                : {cache2DDR_wr_addr, cache2DDR_wr_data};
    assign rd_addr_eff = rd_pend ? rd_slot_q : cache2DDR_rd_addr;

    assign wr_cmd_done = !app_en || app_rdy;
    assign wr_dat_done = !app_wdf_wren || app_wdf_rdy;
    assign wr_clr      = (state == ST_WR_ISSUE) && wr_cmd_done && wr_dat_done;
    assign rd_clr      = (state == ST_RD_WAIT) && (app_rd_data_valid || rd_tmo);

    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state             <= ST_IDLE;
            app_en            <= 1'b0;
            app_cmd           <= CMD_WRITE;
            app_addr          <= '0;
            app_wdf_wren      <= 1'b0;
            app_wdf_data      <= '0;
            DDR2cache_wr_fin  <= 1'b0;
            DDR2cache_rd_fin  <= 1'b0;
            DDR2cache_rd_data <= '0;
        end else begin
            DDR2cache_wr_fin <= 1'b0;
            DDR2cache_rd_fin <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (init_calib_complete) begin
                        if (wr_req) begin
                            state        <= ST_WR_ISSUE;
                            app_en       <= 1'b1;
                            app_cmd      <= CMD_WRITE;
                            app_addr     <= ADDR_W'(line_align(64'(wr_addr_eff)));
                            app_wdf_wren <= 1'b1;
                            app_wdf_data <= wr_data_eff;
                        end else if (rd_req) begin
                            state    <= ST_RD_ISSUE;
                            app_en   <= 1'b1;
                            app_cmd  <= CMD_READ;
                            app_addr <= ADDR_W'(line_align(64'(rd_addr_eff)));
                        end
                    end
                end
                // Command and data handshakes retire independently, in either order.
                ST_WR_ISSUE: begin
                    if (app_rdy)     app_en       <= 1'b0;
                    if (app_wdf_rdy) app_wdf_wren <= 1'b0;
                    if (wr_clr) begin
                        DDR2cache_wr_fin <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        DDR2cache_rd_data <= app_rd_data;
                        DDR2cache_rd_fin  <= 1'b1;
                        state             <= ST_IDLE;
                    end else if (rd_tmo) begin
                        DDR2cache_rd_data <= '0;
                        DDR2cache_rd_fin  <= 1'b1;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DDR_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter sits at zero outside RD_WAIT, so each wait starts from a clean count.
    assign rd_tmo = (state == ST_RD_WAIT) && !app_rd_data_valid
                    && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt    <= '0;
            bridge_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_RD_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
            if (rd_tmo) bridge_err <= 1'b1;
        end
    end
`else
    assign rd_tmo     = 1'b0;
    assign bridge_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_ddr_bridge.sv
// Directed bench for cache_ddr_bridge with a transaction-level model checked every cycle.
module tb_cache_ddr_bridge;
    import ddr_bridge_pkg::*;

    localparam int TMO = 64;

    logic         clk = 1'b0, rstn = 1'b0;
    logic [26:0]  cache2DDR_rd_addr = '0, cache2DDR_wr_addr = '0;
    logic         cache2DDR_rd_en = 1'b0, cache2DDR_wr_en = 1'b0;
    logic [127:0] cache2DDR_wr_data = '0, app_rd_data = '0;
    logic         app_rdy = 1'b1, app_wdf_rdy = 1'b1, app_rd_data_valid = 1'b0;
    logic         init_calib_complete = 1'b1;
    logic         DDR2cache_rd_fin, DDR2cache_wr_fin, app_en, app_wdf_wren, app_wdf_end, bridge_err;
    logic [127:0] DDR2cache_rd_data, app_wdf_data;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic [15:0]  app_wdf_mask;

    always #5 clk = ~clk;

    cache_ddr_bridge #(.LINE_W(128), .ADDR_W(27), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .cache2DDR_rd_addr(cache2DDR_rd_addr), .cache2DDR_rd_en(cache2DDR_rd_en),
        .DDR2cache_rd_fin(DDR2cache_rd_fin), .DDR2cache_rd_data(DDR2cache_rd_data),
        .cache2DDR_wr_addr(cache2DDR_wr_addr), .cache2DDR_wr_data(cache2DDR_wr_data),
        .cache2DDR_wr_en(cache2DDR_wr_en), .DDR2cache_wr_fin(DDR2cache_wr_fin),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete), .bridge_err(bridge_err)
    );

    typedef struct {
        logic [2:0]   cmd;
        logic [26:0]  addr;
        logic [127:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           n_chk = 0, n_err = 0, cyc = 0;
    bit           chk_en = 1'b0;
    // Model state: expected fin pulses for the current cycle, held read data, sticky error.
    logic         exp_rd_fin = 1'b0, exp_wr_fin = 1'b0, exp_err = 1'b0;
    logic         nx_rd_fin, nx_wr_fin;
    logic [127:0] exp_rd_data = '0;
    bit           rd_out = 1'b0, w_cmd_ok = 1'b0, w_dat_ok = 1'b0;
    int           wait_cyc = 0;
    int           n_wr_fin = 0, n_rd_fin = 0, n_acc = 0, n_wren_cyc = 0;
    int           wr_fin_cyc = 0, rd_fin_cyc = 0, acc_cyc = 0;
    logic [26:0]  acc_addr = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chki(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_fin", DDR2cache_rd_fin, exp_rd_fin);
            chk("wr_fin", DDR2cache_wr_fin, exp_wr_fin);
            chk("rd_data", DDR2cache_rd_data, exp_rd_data);
            chk("bridge_err", bridge_err, exp_err);
            chk("wdf_mask", app_wdf_mask, 128'd0);
            chk("wdf_end", app_wdf_end, app_wdf_wren);
            if (app_en) begin
                chk("app_en_calib", init_calib_complete, 128'd1);
                if (exp_q.size() == 0) chk("app_en_unexpected", app_en, 128'd0);
                else begin
                    chk("app_cmd", app_cmd, exp_q[0].cmd);
                    chk("app_addr", app_addr, exp_q[0].addr);
                end
            end
            if (app_wdf_wren) begin
                n_wren_cyc++;
                if (exp_q.size() == 0) chk("wren_unexpected", app_wdf_wren, 128'd0);
                else chk("wdf_data", app_wdf_data, exp_q[0].data);
            end
            if (DDR2cache_wr_fin) begin n_wr_fin++; wr_fin_cyc = cyc; end
            if (DDR2cache_rd_fin) begin n_rd_fin++; rd_fin_cyc = cyc; end

            nx_rd_fin = 1'b0;
            nx_wr_fin = 1'b0;
            if (rd_out) begin
                if (app_rd_data_valid) begin
                    nx_rd_fin   = 1'b1;
                    exp_rd_data = app_rd_data;
                    rd_out      = 1'b0;
                end else begin
                    wait_cyc++;
`ifdef DDR_BRIDGE_TIMEOUT_EN
                    if (wait_cyc == TMO) begin
                        nx_rd_fin   = 1'b1;
                        exp_rd_data = '0;
                        exp_err     = 1'b1;
                        rd_out      = 1'b0;
                    end
`endif
                end
            end
            if (app_en && app_rdy) begin
                n_acc++;
                acc_cyc  = cyc;
                acc_addr = app_addr;
                if (exp_q.size() != 0) begin
                    if (exp_q[0].cmd == CMD_READ) begin
                        void'(exp_q.pop_front());
                        rd_out   = 1'b1;
                        wait_cyc = 0;
                    end else w_cmd_ok = 1'b1;
                end
            end
            if (app_wdf_wren && app_wdf_rdy) w_dat_ok = 1'b1;
            if (w_cmd_ok && w_dat_ok) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nx_wr_fin = 1'b1;
                w_cmd_ok  = 1'b0;
                w_dat_ok  = 1'b0;
            end
            if (!rstn) begin
                nx_rd_fin   = 1'b0;
                nx_wr_fin   = 1'b0;
                exp_rd_data = '0;
                exp_err     = 1'b0;
                rd_out      = 1'b0;
                w_cmd_ok    = 1'b0;
                w_dat_ok    = 1'b0;
                exp_q.delete();
            end
            exp_rd_fin = nx_rd_fin;
            exp_wr_fin = nx_wr_fin;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_wr(input logic [26:0] a, input logic [127:0] d);
        exp_q.push_back('{CMD_WRITE, a & ~27'hF, d});
        cache2DDR_wr_addr = a; cache2DDR_wr_data = d; cache2DDR_wr_en = 1'b1;
        tick(1);
        cache2DDR_wr_en = 1'b0;
    endtask

    task automatic pulse_rd(input logic [26:0] a);
        exp_q.push_back('{CMD_READ, a & ~27'hF, 128'd0});
        cache2DDR_rd_addr = a; cache2DDR_rd_en = 1'b1;
        tick(1);
        cache2DDR_rd_en = 1'b0;
    endtask

    task automatic wait_wr(input int base);
        for (int i = 0; i < 300 && n_wr_fin == base; i++) tick(1);
        chki("wr_fin_count", n_wr_fin, base + 1);
    endtask

    task automatic wait_rd(input int base);
        for (int i = 0; i < 300 && n_rd_fin == base; i++) tick(1);
        chki("rd_fin_count", n_rd_fin, base + 1);
    endtask

    // Acts as the controller: returns data lat cycles after the read was accepted.
    task automatic serve_read(input int lat, input logic [127:0] d);
        for (int i = 0; i < 100 && !rd_out; i++) tick(1);
        chki("rd_accepted", int'(rd_out), 1);
        tick(lat);
        app_rd_data = d; app_rd_data_valid = 1'b1;
        tick(1);
        app_rd_data_valid = 1'b0;
    endtask

    initial begin
        int p, b, b2;
        tick(3);
        chk_en = 1'b1;
        chk("rst_app_en", app_en, 128'd0);
        chk("rst_app_cmd", app_cmd, 128'd0);
        chk("rst_app_addr", app_addr, 128'd0);
        chk("rst_wren", app_wdf_wren, 128'd0);
        chk("rst_rd_data", DDR2cache_rd_data, 128'd0);
        chk("rst_err", bridge_err, 128'd0);
        rstn = 1'b1;
        tick(2);

        // Single write, controller always ready.
        b = n_wr_fin; p = cyc;
        pulse_wr(27'h0001230, {16{8'hA5}});
        wait_wr(b);
        chki("t1_fin_lat", wr_fin_cyc - p, 2);
        chk("t1_addr", acc_addr, 128'h0001230);

        // Single read, data 10 cycles after acceptance.
        b = n_rd_fin; p = cyc;
        pulse_rd(27'h0001234);
        tick(10);
        app_rd_data = 128'h00112233445566778899AABBCCDDEEFF; app_rd_data_valid = 1'b1;
        tick(1);
        app_rd_data_valid = 1'b0;
        wait_rd(b);
        chki("t2_fin_lat", rd_fin_cyc - p, 12);
        chk("t2_addr", acc_addr, 128'h0001230);
        chk("t2_data", DDR2cache_rd_data, 128'h00112233445566778899AABBCCDDEEFF);

        // Same-cycle read and write: write goes first, read issues right after wr_fin.
        b = n_wr_fin; b2 = n_rd_fin;
        exp_q.push_back('{CMD_WRITE, 27'h0000400, 128'hDEADBEEF_00000001_CAFEF00D_12345678});
        exp_q.push_back('{CMD_READ, 27'h0000800, 128'd0});
        cache2DDR_wr_addr = 27'h0000407; cache2DDR_wr_data = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
        cache2DDR_rd_addr = 27'h0000808;
        cache2DDR_wr_en = 1'b1; cache2DDR_rd_en = 1'b1;
        tick(1);
        cache2DDR_wr_en = 1'b0; cache2DDR_rd_en = 1'b0;
        wait_wr(b);
        serve_read(0, 128'h0F0E0D0C0B0A09080706050403020100);
        wait_rd(b2);
        chki("t3_rd_after_wr", acc_cyc - wr_fin_cyc, 1);
        chk("t3_data", DDR2cache_rd_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // Write data held off until cycle 5.
        b = n_wr_fin; b2 = n_wren_cyc; p = cyc;
        app_wdf_rdy = 1'b0;
        pulse_wr(27'h1FFFFFF, 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA);
        tick(4);
        app_wdf_rdy = 1'b1;
        wait_wr(b);
        chki("t4_fin_lat", wr_fin_cyc - p, 6);
        chki("t4_cmd_acc", acc_cyc - p, 1);
        chki("t4_wren_cycles", n_wren_cyc - b2, 5);

        // Read latched during calibration waits for init_calib_complete.
        init_calib_complete = 1'b0;
        b = n_rd_fin; b2 = n_acc;
        pulse_rd(27'h00ABCD7);
        tick(20);
        chki("t5_no_cmd", n_acc, b2);
        init_calib_complete = 1'b1;
        serve_read(2, 128'hFEDCBA98_76543210_FEDCBA98_76543210);
        wait_rd(b);
        chk("t5_addr", acc_addr, 128'h00ABCD0);
        chk("t5_data", DDR2cache_rd_data, 128'hFEDCBA98_76543210_FEDCBA98_76543210);

        // Reset during RD_WAIT abandons the read; a late valid is ignored.
        b = n_rd_fin;
        pulse_rd(27'h0000010);
        for (int i = 0; i < 50 && !rd_out; i++) tick(1);
        chki("t6_rd_accepted", int'(rd_out), 1);
        tick(2);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(3);
        app_rd_data = 128'h1; app_rd_data_valid = 1'b1;
        tick(1);
        app_rd_data_valid = 1'b0;
        tick(5);
        chki("t6_no_fin", n_rd_fin, b);
        chk("t6_data_zero", DDR2cache_rd_data, 128'd0);
        chk("t6_app_en", app_en, 128'd0);

        // Normal service resumes after the reset.
        b = n_rd_fin;
        pulse_rd(27'h0000458);
        serve_read(1, 128'h600D_600D);
        wait_rd(b);
        chk("t6b_data", DDR2cache_rd_data, 128'h600D_600D);

`ifdef DDR_BRIDGE_TIMEOUT_EN
        // No read data ever arrives: watchdog completes with zero data and flags the error.
        b = n_rd_fin;
        pulse_rd(27'h0000020);
        wait_rd(b);
        chki("t7_tmo_lat", rd_fin_cyc - acc_cyc, TMO + 1);
        chk("t7_data_zero", DDR2cache_rd_data, 128'd0);
        tick(3);
        chk("t7_err_sticky", bridge_err, 128'd1);
`endif

        tick(3);
        chki("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
